// File: rtl/capture_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : capture_tx_pkg
// Description : Shared types and constants for the capture-and-serialize
//               transmitter: TX state encoding, UART framing levels and the
//               data width of one serial character.
// Revision    : 1.0 - initial release
// ============================================================================
package capture_tx_pkg;

    // PARITY is only reachable when CAPTURE_PARITY_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : capture_fifo
// Description : Small synchronous FIFO that buffers captured samples until the
//               transmitter can send them. A pop and a push on the same edge
//               are both honoured even when the FIFO is full, because the pop
//               frees the slot the push writes into.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               push, din   - write request and data
//               pop, dout   - read request, head entry (valid while !empty)
//               count       - number of stored entries (0..DEPTH)
//               full, empty - occupancy flags
// ============================================================================
module capture_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [3:0]       count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == 4'(DEPTH));
    assign empty = (count_q == 4'd0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Requests that would corrupt state are ignored rather than trusted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/tt_um_capture_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_capture_serial_tx
// Description : Captures ui_in on a rising edge of the strobe (uio_in[0]),
//               buffers samples in a FIFO and sends each one UART-framed
//               (start, 8 data bits LSB first, optional even parity, stop) on
//               uo_out[0].
// Revision    : 1.0 - initial release
// Macro       : CAPTURE_PARITY_EN - inserts an even-parity bit after the data
//               bits and drives uo_out[7]=1.
// Ports       : clk      - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               ena      - design selected; gates capture only
//               ui_in    - sample data
//               uio_in   - [0] capture strobe, [1] overflow clear
//               uo_out   - [0] txd, [1] busy, [2] empty, [3] overflow,
//                          [6:4] FIFO count, [7] parity-enabled indicator
//               uio_out  - constant 0
//               uio_oe   - constant 0 (all uio pins are inputs)
// ============================================================================
module tt_um_capture_serial_tx
    import capture_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
`ifdef CAPTURE_PARITY_EN
    localparam logic PARITY_IND = 1'b1;
`else
    localparam logic PARITY_IND = 1'b0;
`endif

    tx_state_t       state_q, state_d;
    logic [7:0]      baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;
    logic            strobe_q;
`ifdef CAPTURE_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic            capture;
    logic            fifo_push, fifo_pop;
    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_dout;
    logic [3:0]      fifo_count;
    logic [2:0]      count_field;
    logic            baud_term;
    logic            unused_inputs;

    capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (ui_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Rising edge of the strobe while selected; a held strobe captures once.
    assign capture   = uio_in[0] && !strobe_q && ena;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    // A full FIFO still accepts a sample when the head leaves on this edge.
    assign fifo_push = capture && (!fifo_full || fifo_pop);
    assign baud_term = (baud_q == BAUD_LAST);

    // Overflow flag: set has priority over a same-edge clear.
    always_comb begin
        ovf_d = ovf_q;
        if (uio_in[1])                          ovf_d = 1'b0;
        if (capture && fifo_full && !fifo_pop)  ovf_d = 1'b1;
    end

    // TX framing. txd_d is the line level for the cycle after this edge, so
    // txd leaves a flop and never glitches.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
`ifdef CAPTURE_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                txd_d  = STOP_BIT;
                baud_d = 8'd0;
                if (fifo_pop) begin
                    state_d  = ST_START;
                    shift_d  = fifo_dout;
                    txd_d    = START_BIT;
`ifdef CAPTURE_PARITY_EN
                    parity_d = even_parity(fifo_dout);
`endif
                end
            end
            ST_START: begin
                if (baud_term) begin
                    state_d = ST_DATA;
                    baud_d  = 8'd0;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d  = baud_q + 8'd1;
                end
            end
            ST_DATA: begin
                if (baud_term) begin
                    baud_d = 8'd0;
                    if (bit_q == LAST_BIT) begin
`ifdef CAPTURE_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = ST_STOP;
                        txd_d   = STOP_BIT;
`endif
                    end else begin
                        // shift_q[0] is on the line now; bit 1 goes next.
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
`ifdef CAPTURE_PARITY_EN
            ST_PARITY: begin
                if (baud_term) begin
                    state_d = ST_STOP;
                    baud_d  = 8'd0;
                    txd_d   = STOP_BIT;
                end else begin
                    baud_d  = baud_q + 8'd1;
                end
            end
`endif
            ST_STOP: begin
                // Returning to IDLE guarantees one idle cycle between frames.
                txd_d = STOP_BIT;
                if (baud_term) begin
                    state_d = ST_IDLE;
                    baud_d  = 8'd0;
                end else begin
                    baud_d  = baud_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = 8'd0;
                txd_d   = STOP_BIT;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= 8'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            txd_q    <= STOP_BIT;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            strobe_q <= 1'b0;
`ifdef CAPTURE_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            strobe_q <= uio_in[0];
`ifdef CAPTURE_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // A depth-8 FIFO can hold 8 entries; the 3-bit field saturates at 7.
    assign count_field = fifo_count[3] ? 3'b111 : fifo_count[2:0];

    assign uo_out  = {PARITY_IND, count_field, ovf_q, fifo_empty, busy_q, txd_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    assign unused_inputs = &{1'b0, uio_in[7:2]};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_capture_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_capture_serial_tx
// Description : Self-checking bench for tt_um_capture_serial_tx. A reference
//               model (byte queue plus a queue of expected line levels per
//               frame) predicts uo_out every cycle; a small UART receiver
//               decodes the line so the received byte stream can be checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_capture_serial_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef CAPTURE_PARITY_EN
    localparam int         NB      = 11;
    localparam logic       PAR     = 1'b1;
    localparam logic [7:0] RST_VAL = 8'h85;
`else
    localparam int         NB      = 10;
    localparam logic       PAR     = 1'b0;
    localparam logic [7:0] RST_VAL = 8'h05;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [1:0] wave[$];      // {busy, txd} for each coming cycle of a frame
    logic       m_strobe, m_ovf, m_busy, m_txd;

    // Receiver state
    logic [7:0] rx_q[$];
    logic       rx_active;
    int         rx_t;
    logic [7:0] rx_byte;

    tt_um_capture_serial_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        wave.delete();
        m_strobe  = 1'b0;
        m_ovf     = 1'b0;
        m_busy    = 1'b0;
        m_txd     = 1'b1;
        rx_active = 1'b0;
    endtask

    // One rising edge of the reference model.
    task automatic model_edge(input logic [7:0] ui, input logic [7:0] uio, input logic en);
        logic       cap, pop, full;
        logic [7:0] b;
        logic [10:0] fr;
        logic [1:0] e;
        cap  = uio[0] && !m_strobe && en;
        full = (mq.size() == DEPTH);
        pop  = (wave.size() == 0) && (mq.size() > 0);
        if (pop) begin
            b  = mq.pop_front();
            fr = {1'b1, 1'b1, b, 1'b0};
            if (PAR) fr[9] = ^b;
            for (int i = 0; i < NB; i++)
                for (int k = 0; k < CPB; k++)
                    wave.push_back({1'b1, fr[i]});
            wave.push_back(2'b01);            // mandatory idle cycle
        end
        if (cap && (!full || pop)) mq.push_back(ui);
        if (cap && full && !pop)   m_ovf = 1'b1;
        else if (uio[1])           m_ovf = 1'b0;
        m_strobe = uio[0];
        e = (wave.size() > 0) ? wave.pop_front() : 2'b01;
        m_busy = e[1];
        m_txd  = e[0];
    endtask

    function automatic logic [7:0] exp_uo();
        return {PAR, 3'(mq.size()), m_ovf, (mq.size() == 0), m_busy, m_txd};
    endfunction

    task automatic rx_sample();
        if (!rx_active) begin
            if (uo_out[0] == 1'b0) begin
                rx_active = 1'b1;
                rx_t      = 0;
                rx_byte   = 8'h00;
            end
        end else begin
            rx_t++;
            if (rx_t >= CPB && rx_t < 9 * CPB && (rx_t % CPB) == CPB / 2)
                rx_byte[rx_t / CPB - 1] = uo_out[0];
            if (rx_t == (NB - 1) * CPB + CPB / 2) begin
                rx_q.push_back(rx_byte);
                rx_active = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [7:0] ui, input logic [7:0] uio, input logic en);
        ui_in  = ui;
        uio_in = uio;
        ena    = en;
        @(posedge clk);
        model_edge(ui, uio, en);
        #1;
        chk("cycle", uo_out, exp_uo());
        rx_sample();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 8'h00, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((wave.size() != 0 || mq.size() != 0) && n < 3000) begin
            step(8'h00, 8'h00, 1'b1);
            n++;
        end
        chk("drain_timeout", {7'd0, n < 3000}, 8'd1);
    endtask

    initial begin
        logic [10:0] exp_frame;
        logic [7:0]  exp5 [5];
        logic [7:0]  exp6 [6];
        int          n;

        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_uo", uo_out, RST_VAL);
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'h00);
        rst_n = 1'b1;
        idle(3);

        // Single frame of 0xA5
        exp_frame = {1'b1, 1'b1, 8'hA5, 1'b0};
        if (PAR) exp_frame[9] = 1'b0;
        rx_q.delete();
        step(8'hA5, 8'h01, 1'b1);
        chk("a5_count", {5'd0, uo_out[6:4]}, 8'd1);
        chk("a5_idle_line", {7'd0, uo_out[0]}, 8'd1);
        step(8'h00, 8'h00, 1'b1);
        chk("a5_start", {7'd0, uo_out[0]}, 8'd0);
        for (int c = 1; c < NB * CPB; c++) begin
            step(8'h00, 8'h00, 1'b1);
            if (c % CPB == 1) chk("a5_bit", {7'd0, uo_out[0]}, {7'd0, exp_frame[c / CPB]});
        end
        chk("a5_busy_last", {7'd0, uo_out[1]}, 8'd1);
        step(8'h00, 8'h00, 1'b1);
        chk("a5_busy_end", {7'd0, uo_out[1]}, 8'd0);
        chk("a5_rx_len", 8'(rx_q.size()), 8'd1);
        chk("a5_rx", (rx_q.size() > 0) ? rx_q[0] : 8'h5A, 8'hA5);
        idle(2);

        // Overflow: one frame in flight, then five strobes
        rx_q.delete();
        step(8'hEE, 8'h01, 1'b1);
        step(8'h00, 8'h00, 1'b1);
        for (int v = 1; v <= 5; v++) begin
            step(8'(v), 8'h01, 1'b1);
            step(8'h00, 8'h00, 1'b1);
        end
        chk("ovf_count", {5'd0, uo_out[6:4]}, 8'd4);
        chk("ovf_flag", {7'd0, uo_out[3]}, 8'd1);
        step(8'h00, 8'h02, 1'b1);
        chk("ovf_clear", {7'd0, uo_out[3]}, 8'd0);
        drain();
        exp5 = '{8'hEE, 8'h01, 8'h02, 8'h03, 8'h04};
        chk("ovf_rx_len", 8'(rx_q.size()), 8'd5);
        for (int i = 0; i < 5; i++)
            chk("ovf_rx", (rx_q.size() > i) ? rx_q[i] : ~exp5[i], exp5[i]);
        idle(2);

        // Held strobe captures once
        rx_q.delete();
        step(8'h3C, 8'h01, 1'b1);
        chk("hold_count", {5'd0, uo_out[6:4]}, 8'd1);
        for (int i = 0; i < 9; i++) step(8'h3C, 8'h01, 1'b1);
        step(8'h00, 8'h00, 1'b1);
        drain();
        chk("hold_rx_len", 8'(rx_q.size()), 8'd1);
        idle(2);

        // Strobe while deselected
        step(8'h77, 8'h01, 1'b0);
        chk("ena0_count", {5'd0, uo_out[6:4]}, 8'd0);
        idle(6);
        chk("ena0_line", uo_out[1:0], 8'd1);

        // Push on the same edge as a pop from a full FIFO
        rx_q.delete();
        step(8'h10, 8'h01, 1'b1);
        step(8'h00, 8'h00, 1'b1);
        for (int v = 8'h11; v <= 8'h14; v++) begin
            step(8'(v), 8'h01, 1'b1);
            step(8'h00, 8'h00, 1'b1);
        end
        n = 0;
        while (!(wave.size() == 0 && mq.size() == DEPTH) && n < 200) begin
            step(8'h00, 8'h00, 1'b1);
            n++;
        end
        chk("full_pop_wait", {7'd0, n < 200}, 8'd1);
        step(8'h15, 8'h01, 1'b1);
        chk("full_pop_count", {5'd0, uo_out[6:4]}, 8'd4);
        chk("full_pop_ovf", {7'd0, uo_out[3]}, 8'd0);
        drain();
        exp6 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        chk("full_pop_rx_len", 8'(rx_q.size()), 8'd6);
        for (int i = 0; i < 6; i++)
            chk("full_pop_rx", (rx_q.size() > i) ? rx_q[i] : ~exp6[i], exp6[i]);
        idle(2);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [7:0] u;
            u    = 8'($urandom);
            u[0] = ($urandom_range(0, 3) == 0);
            u[1] = ($urandom_range(0, 15) == 0);
            step(8'($urandom), u, ($urandom_range(0, 7) != 0));
        end
        drain();
        idle(2);

        // Reset mid-frame
        step(8'h5A, 8'h01, 1'b1);
        idle(12);
        uio_in = 8'h00;
        rst_n  = 1'b0;
        #1;
        chk("async_reset", uo_out, RST_VAL);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("in_reset", uo_out, RST_VAL);
        end
        rst_n = 1'b1;
        model_reset();
        idle(50);
        chk("post_reset_line", uo_out, RST_VAL);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
